// File: rtl/prod_acc_pkg.sv
// Shared constants and state encoding for the product accumulator.
// PROD_W is the width of one unsigned 5x5 multiplier product.
// State enum drives the frame FSM in prod_acc.
package prod_acc_pkg;

  localparam int PROD_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/prod_acc_add.sv
// Combinational ACC_W-bit adder with carry-out detection for the accumulator.
// Zero latency; purely combinational, so it has no flow control of its own.
// Build option PROD_ACC_SAT_EN clamps the sum to all-ones on carry; otherwise it wraps.
module prod_acc_add
  import prod_acc_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0]  base,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  // Extend both operands by one bit so the carry out of the top bit is visible.
  always_comb begin
    full  = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    carry = full[ACC_W];
`ifdef PROD_ACC_SAT_EN
    // Once clamped, any further non-zero add carries again, so the value stays clamped.
    sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    sum = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/prod_acc.sv
// Sums a frame of multiplier products and presents sum, count and overflow flag.
// Latency: result valid one cycle after the frame-closing beat (in_last or N_TERMS reached).
// Backpressure: in_ready drops while a result is held; it returns once out_ready takes it.
// Build option PROD_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module prod_acc
  import prod_acc_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 8,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_t             state;
  state_t             state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic               accept;
  logic               first;
  logic               closing;
  logic [ACC_W-1:0]   base;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               ovf_nxt;

  // in_ready depends on registered state only, never on out_ready.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid & in_ready;
  assign first    = (state == IDLE);

  // The first beat of a frame adds to zero so the previous frame never leaks in.
  assign base     = first ? '0 : acc;
  assign cnt_nxt  = first ? CNT_W'(1) : cnt + CNT_W'(1);
  assign ovf_nxt  = (first ? 1'b0 : ovf) | carry;
  assign closing  = accept & (in_last | (cnt_nxt == CNT_W'(N_TERMS)));

  prod_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .base  (base),
    .prod  (in_prod),
    .sum   (sum),
    .carry (carry)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: open a frame on the first accept, close it on last/full, release on out_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = closing ? HOLD : ACC;
      ACC:  if (closing) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator and result registers; results hold their value outside HOLD too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        acc <= sum;
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
      end
      if (closing) begin
        out_valid <= 1'b1;
        out_sum   <= sum;
        out_count <= cnt_nxt;
        out_ovf   <= ovf_nxt;
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/prod_acc.md
PROD_ACC -- requirements
Module: prod_acc

Interface
REQ-001 Parameter ACC_W, default 16: accumulator and out_sum width; legal range 10..32.
REQ-002 Parameter N_TERMS, default 8: maximum products per frame; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: in_prod is valid this cycle.
REQ-006 Port in_ready, output, 1: block can accept a product this cycle.
REQ-007 Port in_prod, input, 10: unsigned 5x5 multiplier product p[9:0].
REQ-008 Port in_last, input, 1: marks the final product of the frame; sampled only on an accepted beat.
REQ-009 Port out_valid, output, 1: frame result is presented.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port out_sum, output, ACC_W: sum of the frame's products.
REQ-012 Port out_count, output, CNT_W = $clog2(N_TERMS+1): number of products in the frame.
REQ-013 Port out_ovf, output, 1: an overflow occurred in the frame.

Function
REQ-014 An accept SHALL occur when in_valid and in_ready are both high on a clock edge; no other input beat has any effect.
REQ-015 The state machine SHALL have three states: IDLE (no frame open), ACC (frame open), HOLD (result presented).
REQ-016 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD; it SHALL be registered state only, with no combinational path from out_ready.
REQ-017 An accept in IDLE SHALL load acc with the zero-extended in_prod, set cnt to 1, and set ovf to 0; the first beat SHALL NOT add to the previous frame's value.
REQ-018 An accept in ACC SHALL set acc to acc + zero-extended in_prod and increment cnt by 1.
REQ-019 An accepted beat with in_last=1, or a beat that brings cnt to N_TERMS, SHALL close the frame and move to HOLD on that edge.
REQ-020 If a beat closes the frame, out_valid SHALL rise on the next cycle, carrying out_sum and out_count that include that beat (latency 1 cycle from the closing beat).
REQ-021 A beat that does not close the frame SHALL move IDLE to ACC, or keep the state in ACC.
REQ-022 In HOLD, out_valid, out_sum, out_count and out_ovf SHALL stay stable until out_ready=1.
REQ-023 The output handshake in HOLD SHALL move to IDLE, with out_valid=0 and in_ready=1 in the following cycle; out_sum, out_count and out_ovf SHALL keep their values outside HOLD.
REQ-024 in_valid gaps in ACC SHALL leave acc and cnt unchanged; the block has no timeout.
REQ-025 When N_TERMS=1, every accepted beat SHALL close a frame regardless of in_last.
REQ-026 A carry out of bit ACC_W-1 SHALL set ovf, which stays set until the next frame starts; the behaviour of acc on overflow is defined in Configuration.

Reset
REQ-027 Asserting rst SHALL immediately force the IDLE state and set acc, cnt, ovf, out_valid, out_sum, out_count and out_ovf to 0.
REQ-028 in_ready SHALL be 1 while rst is high and after it is released.
REQ-029 A reset during ACC or HOLD SHALL discard the partial or pending frame; the first accept after reset SHALL start a new frame.

Configuration
REQ-030 With PROD_ACC_SAT_EN defined, an overflowing add SHALL clamp acc to 2^ACC_W-1, and later adds in that frame SHALL keep it clamped.
REQ-031 Without PROD_ACC_SAT_EN, acc SHALL wrap modulo 2^ACC_W; out_ovf behaves the same in both builds.

Structure
REQ-032 Package prod_acc_pkg SHALL hold PROD_W=10 and the state enum {IDLE, ACC, HOLD}.
REQ-033 Sub-module prod_acc_add SHALL hold the ACC_W-bit adder, the carry detection and the macro-selected saturation; it SHALL be purely combinational.

Verification
REQ-034 Defaults; 8 beats of 961 with no in_last -> one cycle after the 8th accept: out_sum=7688, out_count=8, out_ovf=0.
REQ-035 Beats 10, 20, 30 with in_last on the third -> out_sum=60, out_count=3; the next frame 5 with in_last=1 -> out_sum=5.
REQ-036 ACC_W=10; beats 961, 961 with in_last -> without the macro out_sum=898, out_ovf=1; with PROD_ACC_SAT_EN out_sum=1023, out_ovf=1.
REQ-037 Hold out_ready=0 for 5 cycles in HOLD -> out_valid=1 and out_sum stable, in_ready=0; one cycle of out_ready=1 -> IDLE next cycle.
REQ-038 Assert rst after 2 of 3 beats (100, 100), then send 7 with in_last -> out_sum=7, out_count=1.
REQ-039 in_valid toggling 1,0,0,1,0,1 with in_last on the third beat (products 1, 2, 3) -> out_sum=6, out_count=3.
